// File: rtl/scan_harness_pkg.sv
// Shared types and default geometry for the scan I/O harness.
// The state enum is 3 bits wide so all five states are encoded explicitly.
package scan_harness_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    APPLY     = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int DEF_IN_W   = 7;
  localparam int DEF_OUT_W  = 18;
  localparam int DEF_SETTLE = 2;

endpackage

// File: rtl/scan_io_harness_if.sv
// Control, serial stimulus/response and netlist-facing parallel buses of the harness.
// The harness takes the slave side; the test driver and netlist take the master side.
interface scan_io_harness_if #(
  parameter int IN_W  = scan_harness_pkg::DEF_IN_W,
  parameter int OUT_W = scan_harness_pkg::DEF_OUT_W
) ();
  logic             start;
  logic             busy;
  logic             done;
  logic             si;
  logic             si_valid;
  logic             si_ready;
  logic [IN_W-1:0]  pi;
  logic [OUT_W-1:0] po;
  logic             so;
  logic             so_valid;
  logic             so_ready;

  modport slave (
    input  start, si, si_valid, po, so_ready,
    output busy, done, si_ready, pi, so, so_valid
  );

  modport master (
    output start, si, si_valid, po, so_ready,
    input  busy, done, si_ready, pi, so, so_valid
  );
endinterface

// File: rtl/shift_reg_sipo_piso.sv
// Width-W right-shifting register with parallel load and serial in/out (LSB leaves first).
// q_nxt exposes the post-shift value so a caller can latch it on the same edge.
module shift_reg_sipo_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic [W-1:0] q_nxt
);

  if (W == 1) begin : g_one
    assign q_nxt = sin;
  end else begin : g_wide
    assign q_nxt = {sin, q[W-1:1]};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)           q <= '0;
    else if (load)     q <= load_val;
    else if (shift_en) q <= q_nxt;
  end

endmodule

// File: rtl/scan_io_harness.sv
// Serial stimulus-in / serial response-out harness around a combinational netlist:
// shift a vector in, apply it to pi, wait SETTLE cycles, capture po and shift it out.
module scan_io_harness
  import scan_harness_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input logic             clk,
  input logic             rst,
  scan_io_harness_if.slave bus
);

  if (IN_W < 1 || OUT_W < 1 || SETTLE < 1 || SETTLE > 255) begin : g_bad_param
    $error("scan_io_harness: IN_W/OUT_W must be >= 1 and SETTLE in 1..255");
  end

  localparam int IC_W = $clog2(IN_W + 1);
  localparam int OC_W = $clog2(OUT_W + 1);
  localparam logic [IC_W-1:0] IN_LAST  = IC_W'(IN_W - 1);
  localparam logic [OC_W-1:0] OUT_LAST = OC_W'(OUT_W - 1);
  localparam logic [7:0]      SET_LAST = 8'(SETTLE - 1);

  state_t           state;
  logic [IC_W-1:0]  in_cnt;
  logic [OC_W-1:0]  out_cnt;
  logic [7:0]       set_cnt;
  logic [IN_W-1:0]  pi_q;
  logic             busy_q, done_q, si_ready_q, so_valid_q;
  logic [IN_W-1:0]  stim_q, stim_nxt;
  logic [OUT_W-1:0] resp_q, resp_nxt;

  logic stim_shift, last_in, capture, out_shift, last_out;

  assign stim_shift = (state == SHIFT_IN) && bus.si_valid;
  assign last_in    = stim_shift && (in_cnt == IN_LAST);
  assign capture    = (state == APPLY) && (set_cnt == SET_LAST);
  assign out_shift  = so_valid_q && bus.so_ready;
  assign last_out   = out_shift && (out_cnt == OUT_LAST);

  shift_reg_sipo_piso #(.W(IN_W)) u_stim (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift_en (stim_shift),
    .sin      (bus.si),
    .q        (stim_q),
    .q_nxt    (stim_nxt)
  );

  // po is sampled only here; the response register then drains LSB first with zero fill.
  shift_reg_sipo_piso #(.W(OUT_W)) u_resp (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .load_val (bus.po),
    .shift_en (out_shift),
    .sin      (1'b0),
    .q        (resp_q),
    .q_nxt    (resp_nxt)
  );

  // NOTE: reset is synchronous and only sampled inside the clocked block, never in a sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      set_cnt    <= '0;
      pi_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      si_ready_q <= 1'b0;
      so_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          state      <= SHIFT_IN;
          busy_q     <= 1'b1;
          si_ready_q <= 1'b1;
          in_cnt     <= '0;
        end
        SHIFT_IN: if (stim_shift) begin
          in_cnt <= in_cnt + 1'b1;
          if (last_in) begin
            pi_q       <= stim_nxt;
            set_cnt    <= '0;
            si_ready_q <= 1'b0;
            state      <= APPLY;
          end
        end
        APPLY: begin
          set_cnt <= set_cnt + 1'b1;
          if (capture) begin
            so_valid_q <= 1'b1;
            out_cnt    <= '0;
            state      <= SHIFT_OUT;
          end
        end
        SHIFT_OUT: if (out_shift) begin
          out_cnt <= out_cnt + 1'b1;
          if (last_out) begin
            so_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pi       = pi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.si_ready = si_ready_q;
  assign bus.so_valid = so_valid_q;
  assign bus.so       = resp_q[0];

endmodule

// File: tb/tb_scan_io_harness.sv
// Directed bench: loopback vectors, handshake stalls, mid-operation reset, held start,
// and a SETTLE=1 instance whose po lags pi by one cycle.
module tb_scan_io_harness;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_io_harness_if #(.IN_W(7), .OUT_W(18)) b1 ();
  scan_io_harness_if #(.IN_W(7), .OUT_W(14)) b2 ();

  scan_io_harness #(.IN_W(7), .OUT_W(18), .SETTLE(2)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  scan_io_harness #(.IN_W(7), .OUT_W(14), .SETTLE(1)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  // Netlist stand-ins: plain loopback for dut1; for dut2 the upper half lags pi by one cycle.
  logic [6:0] pi_d;
  always @(posedge clk) pi_d <= rst ? 7'd0 : b2.pi;
  assign b1.po = {11'd0, b1.pi};
  assign b2.po = {pi_d, b2.pi};

  int total = 0;
  int bad   = 0;
  logic [6:0] prev_pi = 7'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pi"},       b1.pi,       32'd0);
    check({tag, "_busy"},     b1.busy,     32'd0);
    check({tag, "_so_valid"}, b1.so_valid, 32'd0);
    check({tag, "_si_ready"}, b1.si_ready, 32'd0);
    check({tag, "_done"},     b1.done,     32'd0);
  endtask

  // Shift v into dut1; a gap of gap_len idle cycles is inserted before bit gap_at.
  task automatic shift_in1(input logic [6:0] v, input int gap_at, input int gap_len);
    for (int i = 0; i < 7; i++) begin
      if (i == gap_at) begin
        b1.si_valid = 1'b0;
        repeat (gap_len) begin
          check("pi_hold_gap", b1.pi, prev_pi);
          check("si_ready_gap", b1.si_ready, 32'd1);
          tick();
        end
      end
      b1.si_valid = 1'b1;
      b1.si       = v[i];
      check("pi_hold", b1.pi, prev_pi);
      tick();
    end
    b1.si_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [6:0] v, input int gap_at, input int gap_len,
                         input int stall_at, input int stall_len, input bit hold);
    logic [17:0] exp_so;
    int lat;
    exp_so = {11'd0, v};
    b1.so_ready = 1'b1;
    b1.start    = 1'b1;
    tick();
    if (!hold) b1.start = 1'b0;
    check("busy_rise", b1.busy, 32'd1);
    check("si_ready_rise", b1.si_ready, 32'd1);
    shift_in1(v, gap_at, gap_len);
    check("pi_apply", b1.pi, {25'd0, v});
    lat = 8 + gap_len;
    while (!b1.so_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat, 10 + gap_len);
    for (int b = 0; b < 18; b++) begin
      if (b == stall_at) begin
        b1.so_ready = 1'b0;
        repeat (stall_len) begin
          check("stall_so", b1.so, exp_so[b]);
          check("stall_so_valid", b1.so_valid, 32'd1);
          check("stall_busy", b1.busy, 32'd1);
          tick();
        end
        b1.so_ready = 1'b1;
      end
      check("so_bit", b1.so, exp_so[b]);
      check("so_valid", b1.so_valid, 32'd1);
      check("busy_out", b1.busy, 32'd1);
      tick();
    end
    check("done_pulse", b1.done, 32'd1);
    check("busy_done", b1.busy, 32'd0);
    check("so_valid_done", b1.so_valid, 32'd0);
    tick();
    check("done_clear", b1.done, 32'd0);
    check("idle_busy", b1.busy, 32'd0);
    check("idle_si_ready", b1.si_ready, 32'd0);
    check("pi_keep", b1.pi, {25'd0, v});
    prev_pi = v;
  endtask

  task automatic run2(input logic [6:0] v, input logic [6:0] prev);
    logic [13:0] got;
    int lat;
    got = '0;
    b2.so_ready = 1'b1;
    b2.start    = 1'b1;
    tick();
    b2.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      b2.si_valid = 1'b1;
      b2.si       = v[i];
      tick();
    end
    b2.si_valid = 1'b0;
    check("s1_pi", b2.pi, {25'd0, v});
    lat = 8;
    while (!b2.so_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("s1_latency", lat, 32'd9);
    for (int b = 0; b < 14; b++) begin
      got[b] = b2.so;
      tick();
    end
    check("s1_resp", got, {18'd0, prev, v});
    check("s1_done", b2.done, 32'd1);
    tick();
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      if (b1.done || b1.so_valid || b1.busy) seen++;
      tick();
    end
    check(tag, seen, 32'd0);
  endtask

  initial begin
    b1.start = 1'b0; b1.si = 1'b0; b1.si_valid = 1'b0; b1.so_ready = 1'b1;
    b2.start = 1'b0; b2.si = 1'b0; b2.si_valid = 1'b0; b2.so_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    check("reset_so", b1.so, 32'd0);

    run_vec(7'h59, -1, 0, -1, 0, 1'b0);   // loopback, continuous handshakes
    run_vec(7'h26, -1, 0, 4, 5, 1'b0);    // so_ready stall at bit 4
    run_vec(7'h59, 3, 3, -1, 0, 1'b0);    // si_valid gap mid-shift

    // Reset during APPLY.
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    shift_in1(7'h4B, -1, 0);
    check("rst_apply_pre", b1.pi, 32'h4B);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst_apply");
    watch_no_done("rst_apply_quiet", 20);
    prev_pi = 7'd0;

    // Reset during SHIFT_OUT after three accepted bits.
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    shift_in1(7'h35, -1, 0);
    tick();
    tick();
    check("rst_out_pre", b1.so_valid, 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst_out");
    check("rst_out_so", b1.so, 32'd0);
    watch_no_done("rst_out_quiet", 30);
    prev_pi = 7'd0;

    // start held high across two vectors.
    run_vec(7'h11, -1, 0, -1, 0, 1'b1);
    run_vec(7'h6E, -1, 0, -1, 0, 1'b1);
    b1.start = 1'b0;

    // SETTLE=1 instance with lagging po.
    run2(7'h2A, 7'h00);
    run2(7'h13, 7'h2A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_io_harness.md
Name: scan_io_harness

Overview:
- Serial test harness that drives the primary inputs of a combinational benchmark netlist and reads back its primary outputs. It is the stimulus/response end of the circuit-under-test interface.
- A stimulus vector is shifted in serially, applied in parallel to the netlist inputs, and held for a settle window. The netlist outputs are then captured in parallel and shifted out serially under a valid/ready handshake.
- Used for hardware-in-the-loop checks of netlists produced by the graph tools (locking, resynthesis equivalence).

Parameters:
- IN_W, 7, width of the netlist primary-input vector (pi).
- OUT_W, 18, width of the netlist primary-output vector (po).
- SETTLE, 2, cycles that pi is held before po is sampled. Legal range 1..255.

Ports:
- clk  input  1  sole clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin one test vector; sampled only in IDLE.
- busy  output  1  high from start acceptance until the last response bit is accepted.
- done  output  1  one-cycle pulse after the last response bit is accepted.
- si  input  1  serial stimulus bit, LSB first.
- si_valid  input  1  si is valid this cycle.
- si_ready  output  1  harness accepts si this cycle; high only in SHIFT_IN.
- pi  output  IN_W  parallel stimulus to the netlist.
- po  input  OUT_W  parallel response from the netlist (combinational).
- so  output  1  serial response bit, LSB first.
- so_valid  output  1  so is valid; high only in SHIFT_OUT.
- so_ready  input  1  downstream accepts so.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - State goes to IDLE.
  - pi=0, so=0, so_valid=0, si_ready=0, busy=0, done=0.
  - stim, resp and all counters are cleared.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- FSM states: IDLE, SHIFT_IN, APPLY, SHIFT_OUT, DONE.
- IDLE:
  - start=1 moves to SHIFT_IN and sets busy=1 on the next cycle.
  - start is ignored in every other state.
- SHIFT_IN:
  - si_ready=1.
  - Each cycle with si_valid=1: stim <= {si, stim[IN_W-1:1]}, and in_cnt increments.
  - When the IN_W-th bit is accepted:
    - pi <= final stim value, including the bit accepted that cycle.
    - set_cnt <= 0; state moves to APPLY.
  - pi is unchanged throughout shifting; the netlist never sees a partial vector.
  - si_valid=0 inserts a wait; there is no timeout.
- APPLY:
  - Lasts exactly SETTLE cycles.
  - On the last APPLY cycle:
    - resp <= po.
    - so <= po[0] on the same edge, so so is valid in the first SHIFT_OUT cycle.
    - State moves to SHIFT_OUT.
  - po is sampled nowhere else.
- SHIFT_OUT:
  - so_valid=1 and so=resp[0].
  - On each so_valid && so_ready: resp shifts right with zero fill, and out_cnt increments.
  - so and so_valid stay stable while so_ready=0.
  - When the OUT_W-th bit is accepted: so_valid=0, busy=0, state moves to DONE.
- DONE:
  - done=1 for one cycle, then IDLE.
  - start asserted during DONE is ignored; it is accepted on the following IDLE cycle.
- pi holds the last applied vector until the next APPLY entry or reset.
- Counters:
  - in_cnt is $clog2(IN_W+1) bits; out_cnt is $clog2(OUT_W+1) bits; set_cnt is 8 bits.
  - All counters reset to 0 on state entry.
  - No wrap-around occurs within a legal operation.
- Latency from start to first so_valid: 1 + IN_W + SETTLE cycles, given continuous si_valid.
- Elaboration error if IN_W<1, OUT_W<1, or SETTLE is outside 1..255.

Decomposition:
- Package scan_harness_pkg holds:
  - the state enum (IDLE, SHIFT_IN, APPLY, SHIFT_OUT, DONE), 3 bits;
  - default width constants.
- One natural sub-module, shift_reg_sipo_piso: a parameterised width-W shift register with load, shift-enable and serial in/out. It is instantiated twice, once for stimulus (serial in) and once for response (parallel load, serial out).

Test Plan:
- Loopback (po = zero-extended pi), IN_W=7, OUT_W=18, SETTLE=2, stimulus bits 1,0,0,1,1,0,1, continuous si_valid and so_ready:
  - pi=7'h59 at APPLY;
  - so sequence 1,0,0,1,1,0,1 followed by eleven 0s;
  - done pulses once;
  - first so_valid 10 cycles after start.
- si_valid low for 3 cycles mid-shift:
  - pi is unchanged until the 7th accepted bit;
  - final pi is identical to the continuous case.
- so_ready held low for 5 cycles at bit 4:
  - so and so_valid are stable during the stall;
  - bit order is unchanged;
  - busy stays high until the 18th bit is accepted.
- rst asserted during APPLY and again during SHIFT_OUT:
  - next cycle pi=0, busy=0, so_valid=0;
  - no done pulse.
- start held high continuously across two vectors:
  - the second vector begins only on the IDLE cycle after DONE;
  - start is ignored while busy.
- SETTLE=1 with a po that changes one cycle after the pi update:
  - the captured resp equals the po value at the end of that single APPLY cycle.
